// File: rtl/alu_arb_pkg.sv
// -----------------------------------------------------------------------------
// alu_arb_pkg
// Shared definitions for the two-requester ALU arbiter: default widths, the
// arbiter FSM state type and the opcode encoding understood by the external
// ALU. The arbiter never decodes opcodes; the constants exist so requesters
// and benches share one encoding.
// -----------------------------------------------------------------------------
package alu_arb_pkg;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_SEL_W   = 4;
  localparam int DEF_SHAMT_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // waiting for a request; grant is presented on reqN_ready
    EXEC = 2'd1,  // operands are on alu_*; result is captured at the end
    RESP = 2'd2   // result held on rsp_* until the owner takes it
  } state_t;

  // External ALU opcode encoding. Codes 12-15 are unused and pass through.
  localparam logic [DEF_SEL_W-1:0] OP_AND = 4'b0000;
  localparam logic [DEF_SEL_W-1:0] OP_OR  = 4'b0001;
  localparam logic [DEF_SEL_W-1:0] OP_ADD = 4'b0010;
  localparam logic [DEF_SEL_W-1:0] OP_SUB = 4'b0011;
  localparam logic [DEF_SEL_W-1:0] OP_XOR = 4'b0100;
  localparam logic [DEF_SEL_W-1:0] OP_NOR = 4'b0101;
  localparam logic [DEF_SEL_W-1:0] OP_SLT = 4'b0110;
  localparam logic [DEF_SEL_W-1:0] OP_SLL = 4'b0111;
  localparam logic [DEF_SEL_W-1:0] OP_SRL = 4'b1000;
  localparam logic [DEF_SEL_W-1:0] OP_ROL = 4'b1001;
  localparam logic [DEF_SEL_W-1:0] OP_ROR = 4'b1010;
  localparam logic [DEF_SEL_W-1:0] OP_ASR = 4'b1011;

endpackage

// File: rtl/alu_rr_pick.sv
// -----------------------------------------------------------------------------
// alu_rr_pick
// Two-way round-robin picker. A lone valid requester always wins; when both
// are valid the one that was NOT granted last time wins.
//
// Ports:
//   valid0, valid1 : request valids
//   last_grant     : index (0/1) of the most recently accepted requester
//   grant[1:0]     : one-hot grant (bit N = requester N), 0 when none valid
// -----------------------------------------------------------------------------
module alu_rr_pick (
  input  logic       valid0,
  input  logic       valid1,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    // NOTE: assign every combinational output a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    grant = 2'b00;
    if (valid0 && valid1) begin
      grant = last_grant ? 2'b01 : 2'b10;
    end else if (valid0) begin
      grant = 2'b01;
    end else if (valid1) begin
      grant = 2'b10;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
// Shares one external combinational ALU between two requesters. Exactly one
// operation is in flight: IDLE grants and accepts, EXEC presents the
// registered operands to the ALU and captures its result, RESP holds the
// result until the owning requester handshakes it.
//
// Parameters: DATA_W (operand/result width), SEL_W (opcode width),
//             SHAMT_W (shift-amount width).
// Ports:
//   clk, rst_n                       : clock, async active-low reset
//   reqN_valid/ready, reqN_a/b,
//   reqN_sel, reqN_shamt (N=0,1)     : request channels
//   rspN_valid/ready (N=0,1)         : response handshakes
//   rsp_data, rsp_zero               : shared registered result
//   alu_in1/in2/sel/shamt            : registered drive to the external ALU
//   alu_out, alu_zero                : external ALU result
//   gnt0_cnt, gnt1_cnt               : saturating acceptance counters, only
//                                      present with ALU_ARB_PERF_CNT_EN defined
// -----------------------------------------------------------------------------
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int SEL_W   = DEF_SEL_W,
  parameter int SHAMT_W = DEF_SHAMT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [DATA_W-1:0]  req0_a,
  input  logic [DATA_W-1:0]  req0_b,
  input  logic [SEL_W-1:0]   req0_sel,
  input  logic [SHAMT_W-1:0] req0_shamt,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [DATA_W-1:0]  req1_a,
  input  logic [DATA_W-1:0]  req1_b,
  input  logic [SEL_W-1:0]   req1_sel,
  input  logic [SHAMT_W-1:0] req1_shamt,
  output logic               rsp0_valid,
  input  logic               rsp0_ready,
  output logic               rsp1_valid,
  input  logic               rsp1_ready,
  output logic [DATA_W-1:0]  rsp_data,
  output logic               rsp_zero,
  output logic [DATA_W-1:0]  alu_in1,
  output logic [DATA_W-1:0]  alu_in2,
  output logic [SEL_W-1:0]   alu_sel,
  output logic [SHAMT_W-1:0] alu_shamt,
  input  logic [DATA_W-1:0]  alu_out,
  input  logic               alu_zero
`ifdef ALU_ARB_PERF_CNT_EN
  ,
  output logic [15:0]        gnt0_cnt,
  output logic [15:0]        gnt1_cnt
`endif
);

  state_t     state_q, state_d;
  logic       last_grant_q;  // index of the most recently accepted requester
  logic       owner_q;       // index of the requester whose op is in flight
  logic [1:0] pick;
  logic       accept;        // valid & ready for one requester this cycle
  logic       rsp_done;      // owner took the response this cycle

  alu_rr_pick u_pick (
    .valid0     (req0_valid),
    .valid1     (req1_valid),
    .last_grant (last_grant_q),
    .grant      (pick)
  );

  // Next-state and handshake outputs. Ready is masked by rst_n so that a
  // requester holding valid through reset never sees a grant while reset
  // is asserted.
  always_comb begin
    state_d    = state_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    accept     = 1'b0;
    rsp_done   = 1'b0;
    case (state_q)
      IDLE: begin
        req0_ready = rst_n & pick[0];
        req1_ready = rst_n & pick[1];
        if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
          accept  = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        state_d = RESP;
      end
      RESP: begin
        if (owner_q ? rsp1_ready : rsp0_ready) begin
          rsp_done = 1'b1;
          state_d  = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Operand capture, result capture and response valids.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;  // requester 0 wins the first tie
      owner_q      <= 1'b0;
      alu_in1      <= '0;
      alu_in2      <= '0;
      alu_sel      <= '0;
      alu_shamt    <= '0;
      rsp_data     <= '0;
      rsp_zero     <= 1'b0;
      rsp0_valid   <= 1'b0;
      rsp1_valid   <= 1'b0;
    end else begin
      if (accept) begin
        // pick is one-hot on acceptance, so pick[1] is the granted index.
        owner_q      <= pick[1];
        last_grant_q <= pick[1];
        alu_in1      <= pick[1] ? req1_a     : req0_a;
        alu_in2      <= pick[1] ? req1_b     : req0_b;
        alu_sel      <= pick[1] ? req1_sel   : req0_sel;
        alu_shamt    <= pick[1] ? req1_shamt : req0_shamt;
      end
      if (state_q == EXEC) begin
        rsp_data   <= alu_out;
        rsp_zero   <= alu_zero;
        rsp0_valid <= ~owner_q;
        rsp1_valid <= owner_q;
      end
      if (rsp_done) begin
        rsp0_valid <= 1'b0;
        rsp1_valid <= 1'b0;
      end
    end
  end

`ifdef ALU_ARB_PERF_CNT_EN
  // Per-requester acceptance counters, saturating at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt0_cnt <= '0;
      gnt1_cnt <= '0;
    end else if (accept) begin
      if (!pick[1] && (gnt0_cnt != 16'hFFFF)) gnt0_cnt <= gnt0_cnt + 16'd1;
      if ( pick[1] && (gnt1_cnt != 16'hFFFF)) gnt1_cnt <= gnt1_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
// Directed bench for alu_arbiter. Provides a small combinational ALU on the
// alu_* port, drives inputs on the falling edge and samples 1 ns later.
// Expected results are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;
  import alu_arb_pkg::*;

  localparam int DW = 32;
  localparam int SW = 4;
  localparam int HW = 6;

  logic          clk, rst_n;
  logic          req0_valid, req0_ready, req1_valid, req1_ready;
  logic [DW-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [SW-1:0] req0_sel, req1_sel;
  logic [HW-1:0] req0_shamt, req1_shamt;
  logic          rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [DW-1:0] rsp_data;
  logic          rsp_zero;
  logic [DW-1:0] alu_in1, alu_in2, alu_out;
  logic [SW-1:0] alu_sel;
  logic [HW-1:0] alu_shamt;
  logic          alu_zero;
`ifdef ALU_ARB_PERF_CNT_EN
  logic [15:0]   gnt0_cnt, gnt1_cnt;
`endif

  int checks = 0;
  int errors = 0;

  alu_arbiter #(.DATA_W(DW), .SEL_W(SW), .SHAMT_W(HW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_sel   (req0_sel),
    .req0_shamt (req0_shamt),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_sel   (req1_sel),
    .req1_shamt (req1_shamt),
    .rsp0_valid (rsp0_valid),
    .rsp0_ready (rsp0_ready),
    .rsp1_valid (rsp1_valid),
    .rsp1_ready (rsp1_ready),
    .rsp_data   (rsp_data),
    .rsp_zero   (rsp_zero),
    .alu_in1    (alu_in1),
    .alu_in2    (alu_in2),
    .alu_sel    (alu_sel),
    .alu_shamt  (alu_shamt),
    .alu_out    (alu_out),
    .alu_zero   (alu_zero)
`ifdef ALU_ARB_PERF_CNT_EN
    ,
    .gnt0_cnt   (gnt0_cnt),
    .gnt1_cnt   (gnt1_cnt)
`endif
  );

  // External ALU stand-in; opcodes not listed produce zero.
  always_comb begin
    alu_out = '0;
    case (alu_sel)
      OP_AND:  alu_out = alu_in1 & alu_in2;
      OP_OR:   alu_out = alu_in1 | alu_in2;
      OP_ADD:  alu_out = alu_in1 + alu_in2;
      OP_SLL:  alu_out = alu_in1 << alu_shamt;
      default: alu_out = '0;
    endcase
  end
  assign alu_zero = (alu_out == '0);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_inputs;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_sel = '0; req0_shamt = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_sel = '0; req1_shamt = '0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
  endtask

  task automatic apply_reset;
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    clear_inputs();
    rst_n = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge clk); #1;
    checks++;
    if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_zero} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 00000",
               {req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_zero});
    end
    checks++;
    if ({rsp_data, alu_in1, alu_in2, alu_sel, alu_shamt} !== '0) begin
      errors++;
      $display("FAIL reset_data: rsp_data=%h in1=%h in2=%h sel=%h shamt=%h expected all 0",
               rsp_data, alu_in1, alu_in2, alu_sel, alu_shamt);
    end
`ifdef ALU_ARB_PERF_CNT_EN
    checks++;
    if ({gnt0_cnt, gnt1_cnt} !== 32'h0) begin
      errors++;
      $display("FAIL reset_cnt: got %h/%h expected 0/0", gnt0_cnt, gnt1_cnt);
    end
`endif
    clear_inputs();
    rst_n = 1'b1;
  endtask

  // REQ-033: single ADD on requester 0, response two cycles after acceptance.
  task automatic test_req0_add;
    req0_valid = 1'b1; req0_a = 32'h1; req0_b = 32'h1; req0_sel = OP_ADD;
    #1;
    checks++;
    if ({req1_ready, req0_ready} !== 2'b01) begin
      errors++; $display("FAIL add_grant: got %b expected 01", {req1_ready, req0_ready});
    end
    @(negedge clk); req0_valid = 1'b0; #1;  // EXEC
    checks++;
    if ({alu_in1, alu_in2, alu_sel, rsp0_valid, rsp1_valid, req0_ready} !== {32'h1, 32'h1, OP_ADD, 3'b000}) begin
      errors++;
      $display("FAIL add_exec: in1=%h in2=%h sel=%h rspv=%b%b rdy=%b expected 1 1 2 00 0",
               alu_in1, alu_in2, alu_sel, rsp0_valid, rsp1_valid, req0_ready);
    end
    @(negedge clk); #1;  // RESP: second cycle after acceptance
    checks++;
    if ({rsp0_valid, rsp1_valid, rsp_zero, rsp_data} !== {3'b100, 32'h2}) begin
      errors++;
      $display("FAIL add_resp: v0=%b v1=%b zero=%b data=%h expected 1 0 0 00000002",
               rsp0_valid, rsp1_valid, rsp_zero, rsp_data);
    end
    @(negedge clk); #1;  // handshake taken
    checks++;
    if (rsp0_valid !== 1'b0) begin
      errors++; $display("FAIL add_done: rsp0_valid=%b expected 0", rsp0_valid);
    end
  endtask

  // REQ-034: AND producing zero on requester 1.
  task automatic test_req1_and;
    req1_valid = 1'b1; req1_a = 32'h1; req1_b = 32'h2; req1_sel = OP_AND;
    #1;
    checks++;
    if ({req1_ready, req0_ready} !== 2'b10) begin
      errors++; $display("FAIL and_grant: got %b expected 10", {req1_ready, req0_ready});
    end
    @(negedge clk); req1_valid = 1'b0;
    @(negedge clk); #1;
    checks++;
    if ({rsp0_valid, rsp1_valid, rsp_zero, rsp_data} !== {3'b011, 32'h0}) begin
      errors++;
      $display("FAIL and_resp: v0=%b v1=%b zero=%b data=%h expected 0 1 1 00000000",
               rsp0_valid, rsp1_valid, rsp_zero, rsp_data);
    end
    @(negedge clk);
  endtask

  // REQ-035/023: simultaneous requests right after reset; req0 first.
  task automatic test_both_after_reset;
    apply_reset();
    req0_valid = 1'b1; req0_a = 32'h1; req0_b = 32'h2; req0_sel = OP_OR;
    req1_valid = 1'b1; req1_a = 32'h1; req1_b = 32'h0; req1_sel = OP_SLL; req1_shamt = 6'd2;
    #1;
    checks++;
    if ({req1_ready, req0_ready} !== 2'b01) begin
      errors++; $display("FAIL tie_grant: got %b expected 01", {req1_ready, req0_ready});
    end
    @(negedge clk); req0_valid = 1'b0; #1;  // EXEC, req1 still waiting
    checks++;
    if ({req1_ready, req0_ready} !== 2'b00) begin
      errors++; $display("FAIL tie_exec_rdy: got %b expected 00", {req1_ready, req0_ready});
    end
    @(negedge clk); #1;  // RESP for req0
    checks++;
    if ({rsp0_valid, rsp1_valid, req1_ready, rsp_data} !== {3'b100, 32'h3}) begin
      errors++;
      $display("FAIL tie_resp0: v0=%b v1=%b r1=%b data=%h expected 1 0 0 00000003",
               rsp0_valid, rsp1_valid, req1_ready, rsp_data);
    end
    @(negedge clk); #1;  // back in IDLE, waiting req1 granted
    checks++;
    if ({req1_ready, req0_ready, rsp0_valid} !== 3'b100) begin
      errors++;
      $display("FAIL tie_grant1: r1=%b r0=%b v0=%b expected 1 0 0", req1_ready, req0_ready, rsp0_valid);
    end
    @(negedge clk); req1_valid = 1'b0; #1;  // EXEC for req1
    checks++;
    if ({alu_sel, alu_shamt, alu_in1} !== {OP_SLL, 6'd2, 32'h1}) begin
      errors++;
      $display("FAIL tie_exec1: sel=%h shamt=%h in1=%h expected 7 02 00000001", alu_sel, alu_shamt, alu_in1);
    end
    @(negedge clk); #1;
    checks++;
    if ({rsp0_valid, rsp1_valid, rsp_data} !== {2'b01, 32'h4}) begin
      errors++;
      $display("FAIL tie_resp1: v0=%b v1=%b data=%h expected 0 1 00000004", rsp0_valid, rsp1_valid, rsp_data);
    end
    @(negedge clk);
  endtask

  // REQ-036: response back-pressure with the other requester waiting.
  task automatic test_stall;
    int bad = 0;
    rsp0_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 32'h5;  req0_b = 32'h7;  req0_sel = OP_ADD;
    req1_valid = 1'b1; req1_a = 32'h10; req1_b = 32'h01; req1_sel = OP_OR;
    #1;
    checks++;
    if ({req1_ready, req0_ready} !== 2'b01) begin
      errors++; $display("FAIL stall_grant: got %b expected 01", {req1_ready, req0_ready});
    end
    @(negedge clk); req0_valid = 1'b0;
    @(negedge clk); #1;
    checks++;
    if ({rsp0_valid, rsp_data} !== {1'b1, 32'hC}) begin
      errors++; $display("FAIL stall_resp: v0=%b data=%h expected 1 0000000c", rsp0_valid, rsp_data);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      if ({rsp0_valid, rsp1_valid, req0_ready, req1_ready} !== 4'b1000 || rsp_data !== 32'hC) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL stall_hold: %0d unstable cycles expected 0", bad);
    end
    rsp0_ready = 1'b1;
    @(negedge clk); #1;
    checks++;
    if ({req1_ready, rsp0_valid} !== 2'b10) begin
      errors++; $display("FAIL stall_release: r1=%b v0=%b expected 1 0", req1_ready, rsp0_valid);
    end
    @(negedge clk); req1_valid = 1'b0;
    @(negedge clk); #1;
    checks++;
    if ({rsp1_valid, rsp_data} !== {1'b1, 32'h11}) begin
      errors++; $display("FAIL stall_resp1: v1=%b data=%h expected 1 00000011", rsp1_valid, rsp_data);
    end
    @(negedge clk);
  endtask

  // REQ-037: reset asserted while an operation is executing.
  task automatic test_reset_in_exec;
    int seen = 0;
    req0_valid = 1'b1; req0_a = 32'h3; req0_b = 32'h4; req0_sel = OP_ADD;
    @(negedge clk); req0_valid = 1'b0;  // EXEC
    rst_n = 1'b0; #1;
    checks++;
    if ({rsp0_valid, rsp1_valid, req0_ready, req1_ready, rsp_zero, rsp_data, alu_in1, alu_in2, alu_sel, alu_shamt} !== '0) begin
      errors++;
      $display("FAIL exec_reset: v=%b%b in1=%h in2=%h sel=%h data=%h expected all 0",
               rsp0_valid, rsp1_valid, alu_in1, alu_in2, alu_sel, rsp_data);
    end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      if (rsp0_valid || rsp1_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL exec_reset_orphan: %0d cycles with rsp valid expected 0", seen);
    end
    req0_valid = 1'b1; req0_a = 32'h10; req0_b = 32'h20; req0_sel = OP_ADD;
    @(negedge clk); req0_valid = 1'b0;
    @(negedge clk); #1;
    checks++;
    if ({rsp0_valid, rsp1_valid, rsp_data} !== {2'b10, 32'h30}) begin
      errors++;
      $display("FAIL exec_reset_next: v0=%b v1=%b data=%h expected 1 0 00000030", rsp0_valid, rsp1_valid, rsp_data);
    end
    @(negedge clk);
  endtask

  // REQ-022: unused opcode and full shamt reach the ALU unchanged.
  task automatic test_passthrough;
    req1_valid = 1'b1; req1_a = 32'hDEADBEEF; req1_b = 32'h12345678;
    req1_sel = 4'hF; req1_shamt = 6'h3F;
    @(negedge clk); req1_valid = 1'b0; #1;
    checks++;
    if ({alu_in1, alu_in2, alu_sel, alu_shamt} !== {32'hDEADBEEF, 32'h12345678, 4'hF, 6'h3F}) begin
      errors++;
      $display("FAIL pass_alu: in1=%h in2=%h sel=%h shamt=%h expected deadbeef 12345678 f 3f",
               alu_in1, alu_in2, alu_sel, alu_shamt);
    end
    @(negedge clk); #1;
    checks++;
    if ({rsp1_valid, rsp_zero, rsp_data} !== {2'b11, 32'h0}) begin
      errors++;
      $display("FAIL pass_resp: v1=%b zero=%b data=%h expected 1 1 00000000", rsp1_valid, rsp_zero, rsp_data);
    end
    @(negedge clk);
  endtask

`ifdef ALU_ARB_PERF_CNT_EN
  // REQ-038: counter saturation after 70000 back-to-back req0 acceptances.
  task automatic test_perf_cnt;
    apply_reset();
    req0_valid = 1'b1; req0_a = 32'h1; req0_b = 32'h1; req0_sel = OP_ADD;
    repeat (70000 * 3) @(negedge clk);
    req0_valid = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    checks++;
    if ({gnt0_cnt, gnt1_cnt} !== {16'hFFFF, 16'h0}) begin
      errors++; $display("FAIL perf_sat: got %h/%h expected ffff/0000", gnt0_cnt, gnt1_cnt);
    end
  endtask
`endif

  initial begin
    clear_inputs();
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    @(negedge clk);
    test_req0_add();
    test_req1_and();
    test_both_after_reset();
    test_stall();
    test_reset_in_exec();
    test_passthrough();
`ifdef ALU_ARB_PERF_CNT_EN
    test_perf_cnt();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the operand and result width.
REQ-002 Parameter SEL_W, default 4, SHALL set the ALU operation-select width.
REQ-003 Parameter SHAMT_W, default 6, SHALL set the shift-amount width.
REQ-004 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-006 reqN_valid  in  1  (N=0,1) SHALL signal that requester N presents an operation.
REQ-007 reqN_ready  out  1  SHALL signal acceptance of requester N's operation this cycle.
REQ-008 reqN_a, reqN_b  in  DATA_W  SHALL carry requester N's operands.
REQ-009 reqN_sel  in  SEL_W; reqN_shamt  in  SHAMT_W  SHALL carry requester N's opcode and shift amount.
REQ-010 rspN_valid  out  1; rspN_ready  in  1  SHALL form requester N's response handshake.
REQ-011 rsp_data  out  DATA_W; rsp_zero  out  1  SHALL carry the shared registered result and zero flag.
REQ-012 alu_in1, alu_in2  out  DATA_W; alu_sel  out  SEL_W; alu_shamt  out  SHAMT_W  SHALL drive the external combinational ALU.
REQ-013 alu_out  in  DATA_W; alu_zero  in  1  SHALL return the ALU result and zero flag.

Function
REQ-014 FSM states IDLE, EXEC, RESP; exactly one operation in flight.
REQ-015 In IDLE, at most one reqN_ready SHALL be high, for the granted requester only; both low in EXEC and RESP.
REQ-016 Grant: single valid requester wins; both valid -> requester other than last_grant wins (round-robin).
REQ-017 Acceptance (valid & ready, edge T) SHALL register operands/opcode/shamt onto alu_* and move IDLE->EXEC.
REQ-018 In EXEC, edge T+1 SHALL capture alu_out/alu_zero into rsp_data/rsp_zero, set rspN_valid for the granted N and move to RESP.
REQ-019 Latency: rspN_valid high in the second cycle after acceptance.
REQ-020 In RESP, rsp_data, rsp_zero, rspN_valid SHALL hold stable until rspN_ready; on handshake, rspN_valid drops and FSM returns to IDLE.
REQ-021 The non-granted rspN_valid SHALL stay low throughout.
REQ-022 Opcodes and shamt SHALL pass through unchanged, including unused codes 12-15; no opcode checking.
REQ-023 A request held valid while the other is serviced SHALL be granted at the next IDLE cycle.
REQ-024 last_grant SHALL update only on acceptance.

Reset
REQ-025 rst_n low SHALL immediately force IDLE; reqN_ready, rspN_valid, rsp_data, rsp_zero, all alu_* outputs to 0.
REQ-026 last_grant SHALL reset to 1 so requester 0 wins the first simultaneous request.
REQ-027 Reset during EXEC or RESP SHALL discard the in-flight operation without any response.

Configuration
REQ-028 With ALU_ARB_PERF_CNT_EN defined, outputs gnt0_cnt and gnt1_cnt (16 bits each) SHALL count acceptances per requester, saturating at 0xFFFF, reset to 0.
REQ-029 Without ALU_ARB_PERF_CNT_EN, those ports and counters SHALL not exist; all other behaviour unchanged.

Structure
REQ-030 Package alu_arb_pkg SHALL hold the FSM state typedef, DATA_W/SEL_W/SHAMT_W defaults and ALU opcode constants (AND=0000, OR=0001, ADD=0010, ... ASR=1011).
REQ-031 Round-robin grant logic SHALL be a sub-module alu_rr_pick (inputs two valids and last_grant, output one-hot grant).
REQ-032 The ALU SHALL be instantiated outside this block.

Verification
REQ-033 req0 ADD 0x1+0x1 (sel 0010) -> rsp0_valid two cycles after acceptance, rsp_data=0x2, rsp_zero=0, rsp1_valid=0.
REQ-034 req1 AND 0x1,0x2 (sel 0000) -> rsp_data=0x0, rsp_zero=1 on rsp1_valid.
REQ-035 Both valid after reset: req0 OR 0x1,0x2 and req1 SLL 0x1 shamt 2 (sel 0111) -> req0 served first (0x3), then req1 (0x4).
REQ-036 rsp0_ready low 5 cycles in RESP -> rsp_data stable, req1_ready stays 0 until handshake.
REQ-037 rst_n low in EXEC -> all outputs 0 at once, no rspN_valid after release, next request served normally.
REQ-038 With ALU_ARB_PERF_CNT_EN, 70000 req0 acceptances -> gnt0_cnt=0xFFFF, gnt1_cnt=0.
